// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled 8-bit LSB-first framing with a one-cycle buffer write strobe.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_deser #(
    parameter int BAUD_DIV  = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 WR,
    output logic [1:0]           wraddr,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync_p0;
    logic                 r_sync_p1;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;

    logic w_rx;
    logic w_tick_half;
    logic w_tick_full;
    logic w_cnt_clr;
    logic w_shift_en;
    logic w_wr_set;
    logic w_ferr_set;
    logic w_perr_set;
    logic w_par_err;

    assign w_rx        = r_sync_p1;
    assign w_tick_half = (r_cnt == HALF_M1);
    assign w_tick_full = (r_cnt == FULL_M1);

    // State register plus the control/output registers
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_sync_p0  <= 1'b1;
            r_sync_p1  <= 1'b1;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            dataOut    <= '0;
            WR         <= 1'b0;
            wraddr     <= 2'd0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sync_p0 <= RxD;
            r_sync_p1 <= r_sync_p0;
            if (w_cnt_clr)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_state == S_IDLE)
                r_bitcnt <= '0;
            else if (w_shift_en)
                r_bitcnt <= r_bitcnt + BW'(1);
            WR <= w_wr_set;
            if (w_wr_set)
                dataOut <= r_shift;
            if (WR)
                wraddr <= wraddr + 2'd1;
            frame_err  <= w_ferr_set;
            parity_err <= w_perr_set;
        end
    end

    // Shift right with the new sample at the MSB: the first bit received ends up at bit 0
    always_ff @(posedge Clk) begin
        if (w_shift_en)
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    logic w_par_load;
    assign w_par_load = (r_state == S_PARITY) && w_tick_full;

    always_ff @(posedge Clk) begin
        if (!Rst)
            r_par_err <= 1'b0;
        else if (w_par_load)
            r_par_err <= ^{r_shift, w_rx};
    end
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx) w_next = S_START;
            S_START:  if (w_tick_half) w_next = w_rx ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_tick_full && (r_bitcnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (w_tick_full) w_next = S_STOP;
            S_STOP:   if (w_tick_full) w_next = w_rx ? S_IDLE : S_BREAK;
            S_BREAK:  if (w_rx) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Every sample point also restarts the baud counter
    always_comb begin
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_wr_set   = 1'b0;
        w_ferr_set = 1'b0;
        w_perr_set = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE, S_BREAK: w_cnt_clr = 1'b1;
            S_START:  w_cnt_clr = w_tick_half;
            S_DATA: begin
                w_cnt_clr  = w_tick_full;
                w_shift_en = w_tick_full;
            end
            S_PARITY: w_cnt_clr = w_tick_full;
            S_STOP: begin
                w_cnt_clr  = w_tick_full;
                w_wr_set   = w_tick_full && w_rx && !w_par_err;
                w_ferr_set = w_tick_full && !w_rx;
                w_perr_set = w_tick_full && w_par_err;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized self-checking bench for uart_rx_deser against a frame-level reference model.
module tb_uart_rx_deser;

    localparam int BAUD = 16;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] dataOut;
    logic       WR;
    logic [1:0] wraddr;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    uart_rx_deser #(.BAUD_DIV(BAUD), .DATA_BITS(8)) dut (
        .Clk(Clk), .Rst(Rst), .RxD(RxD), .dataOut(dataOut), .WR(WR),
        .wraddr(wraddr), .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Observed writes as {addr, byte}, and pulse counts
    logic [9:0] obs_q[$];
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int both_cnt = 0;

    // Reference model: expected writes and the next buffer address
    logic [9:0] exp_q[$];
    int m_addr = 0;
    int exp_ferr = 0;
    int exp_perr = 0;

    always @(negedge Clk) begin
        if (Rst) begin
            if (WR) obs_q.push_back({wraddr, dataOut});
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (WR && frame_err) both_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        perr_cnt = 0;
        both_cnt = 0;
        exp_ferr = 0;
        exp_perr = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0;
        RxD = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        m_addr = 0;
        repeat (4) @(negedge Clk);
        clear_obs();
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (BAUD) @(negedge Clk);
    endtask

    // One character; the model records what the buffer should receive
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
        if (par_flip) exp_perr++;
`endif
        send_bit(stop_ok);
`ifdef UART_RX_PARITY_EN
        if (stop_ok && !par_flip) begin
`else
        if (stop_ok) begin
`endif
            exp_q.push_back({m_addr[1:0], d});
            m_addr = (m_addr + 1) % 4;
        end
        if (!stop_ok) exp_ferr++;
    endtask

    task automatic compare_model(input string tag);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write %0d: got addr=%0d byte=%02h expected addr=%0d byte=%02h",
                         tag, i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
        checks++;
        if (ferr_cnt !== exp_ferr) begin
            errors++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", tag, ferr_cnt, exp_ferr);
        end
        checks++;
        if (perr_cnt !== exp_perr) begin
            errors++;
            $display("FAIL %s parity_err pulses: got %0d expected %0d", tag, perr_cnt, exp_perr);
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL %s WR with frame_err: got %0d cycles expected 0", tag, both_cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RxD = i[0];
            @(negedge Clk);
        end
        checks++;
        if ({WR, busy, wraddr, dataOut, frame_err, parity_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset outputs: got WR=%b busy=%b wraddr=%0d dataOut=%02h ferr=%b perr=%b expected all 0",
                     WR, busy, wraddr, dataOut, frame_err, parity_err);
        end
        RxD = 1'b1;
        Rst = 1'b1;
        m_addr = 0;
        repeat (4) @(negedge Clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle busy: got %b expected 0", busy);
        end
        clear_obs();
    endtask

    task automatic test_single();
        clear_obs();
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (BAUD) @(negedge Clk);
        compare_model("single");
        checks++;
        if (wraddr !== 2'd1) begin
            errors++;
            $display("FAIL single wraddr after: got %0d expected 1", wraddr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single busy after: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (BAUD) @(negedge Clk);
        compare_model("back_to_back");
    endtask

    task automatic test_glitch();
        logic saw_busy;
        clear_obs();
        saw_busy = 1'b0;
        RxD = 1'b0;
        repeat (6) @(negedge Clk);
        RxD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (busy) saw_busy = 1'b1;
        end
        repeat (3 * BAUD) @(negedge Clk);
        compare_model("glitch");
        checks++;
        if (saw_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch start seen: got busy=%b expected 1", saw_busy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch return idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_frame_err();
        logic [1:0] addr_before;
        clear_obs();
        addr_before = wraddr;
        send_frame(8'h3C, 1'b0, 1'b0);
        RxD = 1'b0;
        repeat (40) @(negedge Clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break busy: got %b expected 1", busy);
        end
        RxD = 1'b1;
        repeat (BAUD) @(negedge Clk);
        checks++;
        if (wraddr !== addr_before) begin
            errors++;
            $display("FAIL frame_err wraddr: got %0d expected %0d", wraddr, addr_before);
        end
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (BAUD) @(negedge Clk);
        compare_model("frame_err");
        checks++;
        if (obs_q.size() !== 1 || obs_q[0][9:8] !== addr_before) begin
            errors++;
            $display("FAIL after frame_err addr: got %0d writes expected 1 at addr %0d", obs_q.size(), addr_before);
        end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        clear_obs();
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (BAUD) @(negedge Clk);
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (BAUD) @(negedge Clk);
        send_frame(8'h81, 1'b0, 1'b1);
        RxD = 1'b1;
        repeat (2 * BAUD) @(negedge Clk);
        compare_model("parity");
`endif
    endtask

    task automatic test_random();
        logic       stop_ok;
        logic       par_flip;
        logic [7:0] d;
        clear_obs();
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            stop_ok = ($urandom_range(5) != 0);
`ifdef UART_RX_PARITY_EN
            par_flip = ($urandom_range(4) == 0);
`else
            par_flip = 1'b0;
`endif
            send_frame(d, stop_ok, par_flip);
            if (!stop_ok) begin
                RxD = 1'b0;
                repeat ($urandom_range(30)) @(negedge Clk);
                RxD = 1'b1;
                repeat (8 + $urandom_range(10)) @(negedge Clk);
            end else begin
                RxD = 1'b1;
                repeat ($urandom_range(20)) @(negedge Clk);
            end
        end
        RxD = 1'b1;
        repeat (2 * BAUD) @(negedge Clk);
        compare_model("random");
        checks++;
        if (wraddr !== m_addr[1:0]) begin
            errors++;
            $display("FAIL random final wraddr: got %0d expected %0d", wraddr, m_addr);
        end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        Rst = 1'b0;
        RxD = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({WR, busy, wraddr, dataOut, frame_err, parity_err} !== 14'h0) begin
            errors++;
            $display("FAIL midframe reset outputs: got WR=%b busy=%b wraddr=%0d dataOut=%02h ferr=%b perr=%b expected all 0",
                     WR, busy, wraddr, dataOut, frame_err, parity_err);
        end
        Rst = 1'b1;
        m_addr = 0;
        repeat (12 * BAUD) @(negedge Clk);
        compare_model("midframe_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_parity();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
UART receive deserializer, the stage directly upstream of the 4-entry receive byte buffer. Oversamples the serial RxD line, frames 8-bit LSB-first characters (start, data, optional parity, stop) and emits each good byte with a one-cycle WR strobe and a 2-bit wrap-around write address. Flags framing errors (and parity errors when enabled) and drops those bytes without writing them.

Parameters:
BAUD_DIV, 16, Clk cycles per bit period; legal range 4..65535; counter width is $clog2(BAUD_DIV).
DATA_BITS, 8, data bits per character; fixed to match the 8-bit buffer width.

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-low reset
RxD  input  1  asynchronous serial line; idle high
dataOut  output  8  received byte; valid while WR=1, held until the next good byte
WR  output  1  one-cycle write strobe to the buffer
wraddr  output  2  buffer address for the current WR
busy  output  1  high in every state except IDLE
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when the feature is out

Behaviour:
- Reset (Rst=0 at posedge Clk): state=IDLE; dataOut=8'h00; WR=0; wraddr=0; busy=0; frame_err=0; parity_err=0; synchronizer flops=1; bit counter=0; baud counter=0.
- RxD passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; STOP can also go to BREAK.
- IDLE: when rx_s=0, clear the baud counter and go to START.
- START: count to BAUD_DIV/2-1 (mid-bit), then sample rx_s.
  - rx_s=1: false start, return to IDLE with no outputs.
  - rx_s=0: clear the counter and go to DATA.
- DATA: sample every BAUD_DIV cycles. Shift the sample in at the MSB and shift right, so the byte is LSB first. After the 8th sample, go to PARITY (feature in) or STOP.
- STOP: sample after BAUD_DIV cycles.
  - rx_s=1 and no parity error: in the next cycle dataOut=shift reg and WR=1 for exactly one cycle, with wraddr holding the address being written. wraddr increments by 1 (mod 4, 3->0) the cycle after WR. Return to IDLE.
  - rx_s=0: frame_err=1 for one cycle, no WR, wraddr unchanged, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. A line held low therefore produces exactly one frame_err.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge half a bit later is caught.
- No flow control: the block never stalls. A buffer overrun is the consumer's responsibility.
- WR and frame_err are never high in the same cycle.
- Reset mid-frame aborts the frame: no WR, no error pulse, all outputs return to reset values.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: an even-parity bit follows the data bits. The PARITY state samples it after BAUD_DIV cycles.
  - If XOR(data, parity)=1, parity_err pulses for one cycle in the cycle WR would have asserted. WR is suppressed and wraddr is unchanged.
  - The stop bit is still checked. If the stop bit is also low, the parity_err pulse and the frame_err pulse each occur, and the block goes to BREAK.
- Undefined: no PARITY state; frame is 8N1; parity_err tied to 0.

Test Plan:
- Reset: hold Rst=0 for 3 cycles with RxD toggling -> WR=0, busy=0, wraddr=0, dataOut=8'h00.
- Single frame, BAUD_DIV=16, 8N1 byte 8'hA5 -> exactly one WR pulse with dataOut=8'hA5 and wraddr=0; then wraddr=1 and busy=0.
- Five back-to-back frames 8'h01..8'h05 with no idle gap -> five WR pulses at wraddr 0,1,2,3,0 with the matching bytes.
- Glitch: RxD low for 6 cycles, then high -> no WR, no frame_err, return to IDLE.
- Stop bit forced low on byte 8'h3C, then line held low for 40 cycles -> one frame_err pulse, no WR, wraddr unchanged. The next good frame 8'h7E is written at the same wraddr.
- With UART_RX_PARITY_EN: byte 8'h03 with parity bit 0 -> WR, dataOut=8'h03. Same byte with parity bit 1 -> one parity_err pulse, no WR.
